anc_fir_ctrl: RTL and testbench
===============================

# anc_fir_ctrl

Sample-rate controller and initiator for the adaptive LMS FIR engine. It pairs each reference sample with its error-mic sample and forms the weight update term `mu*e` in Q1.15. It then launches one FIR pass with a single-cycle `fir_go` and waits for the engine's `fir_done`, returning the anti-noise sample downstream. It sits between the audio front-end (ADC/I2S deserialisers) and the FIR engine. It owns transaction pairing, overrun detection and hang recovery.

## Interface
- `TIMEOUT`, default 512: maximum cycles spent in WAIT before abort. Range 2..65535. It must exceed the FIR pass length, which is TAPS+8 cycles.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  when low, IDLE ignores samples and clears the capture flags.
- `x_valid` / `x_data`  in  1 / 16 signed  reference sample strobe and data.
- `e_valid` / `e_data`  in  1 / 16 signed  error sample strobe and data.
- `d_data`  in  16 signed  accumulator seed. Captured with `x_data`.
- `mu`  in  16 signed  Q1.15 step size. Captured with `e_data`.
- `fir_x_in`, `fir_a_in`, `fir_weight_adjust`  out  16 signed each  registered operands to the FIR engine.
- `fir_go`  out  1  one-cycle start pulse to the FIR engine.
- `fir_out_sample`  in  16 signed  FIR result. Sampled only when `fir_done` = 1.
- `fir_done`  in  1  FIR completion pulse.
- `y_data` / `y_valid`  out  16 signed / 1  output anti-noise sample; `y_valid` is a one-cycle pulse.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  one-cycle pulse when a sample is dropped or overwritten.
- `timeout_err`  out  1  one-cycle pulse when WAIT is aborted.

## Operation
- **States:** IDLE, MUL, SAT, GO, WAIT.
- **IDLE, capture:** with `enable` = 1, `x_valid` loads `x_data` and `d_data` and sets `xf`. `e_valid` loads `e_data` and `mu` and sets `ef`.
  - Both strobes in the same cycle are both accepted.
  - A strobe arriving while its own flag is already set overwrites the held value and pulses `overrun`.
  - When `xf` and `ef` are both set (including being set on the same edge), the next state is MUL.
- **MUL:** `prod` (32 bit signed) <= `e_hold` * `mu_hold`. Next state SAT.
- **SAT:**
  - `fir_weight_adjust` <= saturate16(`prod` >>> 15), clamped to [-32768, 32767].
  - `fir_x_in` <= `x_hold`; `fir_a_in` <= `d_hold`.
  - Clear `xf` and `ef`. Next state GO.
- **GO:** `fir_go` = 1 for exactly this one cycle; clear the wait counter. Next state WAIT.
- **WAIT:** the counter increments each cycle.
  - `fir_done` = 1: `y_data` <= `fir_out_sample`, `y_valid` pulses, next state IDLE.
  - Else, counter == TIMEOUT-1: `timeout_err` pulses, `y_data` is unchanged, no `y_valid`, next state IDLE.
- **Strobes outside IDLE:** any `x_valid` or `e_valid` received while not in IDLE is dropped and pulses `overrun`. It does not set a flag.
- **Operand hold:** `fir_x_in`, `fir_a_in` and `fir_weight_adjust` hold their values from SAT until the next SAT, so they are stable across GO and WAIT.
- **`enable` deassert:** a deassert mid-transaction does not abort it; the pass completes. Samples are ignored only while in IDLE.
- **Reset:** all outputs are 0, state is IDLE, flags are cleared. This includes reset mid-WAIT. Any in-flight `fir_done` arriving after reset is ignored because the state is IDLE.

## Timing
- Let E0 be the edge that completes the pair. Then:
  - E1: MUL captures `prod`.
  - E2: SAT registers the operands.
  - Cycle after E2: `fir_go` is high.
  - E3: the FIR engine samples `go` and the operands.
- If `fir_done` is sampled high at edge En, `y_valid` and `y_data` are valid in the cycle after En. `busy` falls at En.
- A new pair can be captured from edge En+1; a strobe at edge En counts as an overrun.
- Throughput is one sample per (FIR pass + 4) cycles.
- `fir_done` seen outside WAIT is ignored and produces no `y_valid`.
- All outputs are registered and there are no combinational paths from input to output.

## Test plan
- **Basic pass:** `x`=0x1000, `d`=0x0100, `e`=0x4000, `mu`=0x4000 in the same cycle, FIR model returns 0x1234 with `fir_done` 136 cycles after `go`.
  - -> `fir_weight_adjust`=0x2000, `fir_x_in`=0x1000, `fir_a_in`=0x0100.
  - -> `fir_go` pulses once, 3 cycles after the capture edge.
  - -> `y_data`=0x1234 with a one-cycle `y_valid`.
- **Saturation:** `e`=0x8000, `mu`=0x8000 -> `fir_weight_adjust`=0x7FFF. `e`=0x8000, `mu`=0x7FFF -> 0x8001.
- **Staggered strobes:** `x_valid` first, then `e_valid` 10 cycles later -> MUL is entered only after `e`. A second `x_valid` arriving before `e` overwrites `x` and gives one `overrun` pulse.
- **Overrun in WAIT:** an `x_valid` during WAIT -> `overrun` pulse, sample dropped, no extra `fir_go`.
- **Timeout:** with TIMEOUT=512 and the FIR model never asserting `done`:
  - -> `timeout_err` exactly 512 cycles after `fir_go`, no `y_valid`, `busy` low.
  - -> the next pair starts normally.
- **Reset mid-WAIT:** assert `rst_n` low 50 cycles into WAIT, then release -> all outputs are 0. A late `fir_done` causes no `y_valid`, and the next pair completes normally.

Source files
------------

// File: rtl/anc_fir_ctrl.sv
// Sample-rate controller for the adaptive LMS FIR engine: pairs reference and
// error samples, forms mu*e in Q1.15, launches one FIR pass and returns y.
module anc_fir_ctrl #(
  parameter int TIMEOUT = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               x_valid,
  input  logic signed [15:0] x_data,
  input  logic               e_valid,
  input  logic signed [15:0] e_data,
  input  logic signed [15:0] d_data,
  input  logic signed [15:0] mu,
  output logic signed [15:0] fir_x_in,
  output logic signed [15:0] fir_a_in,
  output logic signed [15:0] fir_weight_adjust,
  output logic               fir_go,
  input  logic signed [15:0] fir_out_sample,
  input  logic               fir_done,
  output logic signed [15:0] y_data,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, MUL, SAT, GO, WAIT} state_t;

  state_t             state;
  state_t             state_next;
  logic               xf;
  logic               ef;
  logic signed [15:0] x_hold;
  logic signed [15:0] d_hold;
  logic signed [15:0] e_hold;
  logic signed [15:0] mu_hold;
  logic signed [31:0] prod;
  logic signed [31:0] prod_shift;
  logic signed [15:0] sat_val;
  logic [15:0]        cnt;

  logic x_take;
  logic e_take;
  logic pair_ready;
  logic drop;
  logic clobber;

  assign x_take     = (state == IDLE) && enable && x_valid;
  assign e_take     = (state == IDLE) && enable && e_valid;
  // The pair may complete on the very edge that sets the second flag.
  assign pair_ready = (xf || x_take) && (ef || e_take);
  assign drop       = (state != IDLE) && (x_valid || e_valid);
  assign clobber    = (x_take && xf) || (e_take && ef);

  always_comb begin
    prod_shift = prod >>> 15;
    if (prod_shift > 32'sd32767) begin
      sat_val = 16'sh7FFF;
    end else if (prod_shift < -32'sd32768) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = prod_shift[15:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pair_ready) state_next = MUL;
      MUL:     state_next = SAT;
      SAT:     state_next = GO;
      GO:      state_next = WAIT;
      WAIT:    if (fir_done || (cnt == CNT_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      xf                <= 1'b0;
      ef                <= 1'b0;
      x_hold            <= '0;
      d_hold            <= '0;
      e_hold            <= '0;
      mu_hold           <= '0;
      prod              <= '0;
      cnt               <= '0;
      fir_x_in          <= '0;
      fir_a_in          <= '0;
      fir_weight_adjust <= '0;
      fir_go            <= 1'b0;
      y_data            <= '0;
      y_valid           <= 1'b0;
      busy              <= 1'b0;
      overrun           <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      fir_go      <= (state == SAT);
      overrun     <= drop || clobber;
      y_valid     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!enable) begin
            xf <= 1'b0;
            ef <= 1'b0;
          end
          if (x_take) begin
            x_hold <= x_data;
            d_hold <= d_data;
            xf     <= 1'b1;
          end
          if (e_take) begin
            e_hold  <= e_data;
            mu_hold <= mu;
            ef      <= 1'b1;
          end
        end
        MUL: prod <= 32'(e_hold) * 32'(mu_hold);
        SAT: begin
          fir_weight_adjust <= sat_val;
          fir_x_in          <= x_hold;
          fir_a_in          <= d_hold;
          xf                <= 1'b0;
          ef                <= 1'b0;
        end
        GO: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (fir_done) begin
            y_data  <= fir_out_sample;
            y_valid <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anc_fir_ctrl.sv
// Directed self-checking bench for anc_fir_ctrl with a behavioural FIR engine
// whose done latency (or silence) is set per scenario.
module tb_anc_fir_ctrl;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               x_valid = 1'b0;
  logic               e_valid = 1'b0;
  logic signed [15:0] x_data = '0;
  logic signed [15:0] e_data = '0;
  logic signed [15:0] d_data = '0;
  logic signed [15:0] mu = '0;
  logic signed [15:0] fir_x_in;
  logic signed [15:0] fir_a_in;
  logic signed [15:0] fir_weight_adjust;
  logic               fir_go;
  logic signed [15:0] fir_out_sample = '0;
  logic               fir_done = 1'b0;
  logic signed [15:0] y_data;
  logic               y_valid;
  logic               busy;
  logic               overrun;
  logic               timeout_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int go_count = 0, yv_count = 0, ovr_count = 0, to_count = 0;
  int last_go = 0, last_yv = 0, last_to = 0;
  int cap = 0;
  int fir_delay = 136;   // 0 = engine never answers
  int model_cnt = -1;
  logic signed [15:0] fir_result = 16'h1234;

  anc_fir_ctrl #(.TIMEOUT(512)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .x_valid(x_valid), .x_data(x_data), .e_valid(e_valid), .e_data(e_data),
    .d_data(d_data), .mu(mu),
    .fir_x_in(fir_x_in), .fir_a_in(fir_a_in), .fir_weight_adjust(fir_weight_adjust),
    .fir_go(fir_go), .fir_out_sample(fir_out_sample), .fir_done(fir_done),
    .y_data(y_data), .y_valid(y_valid), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Event monitor: cyc is the index of the most recent rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fir_go) begin go_count <= go_count + 1; last_go <= cyc + 1; end
    if (y_valid) begin yv_count <= yv_count + 1; last_yv <= cyc; end
    if (overrun) ovr_count <= ovr_count + 1;
    if (timeout_err) begin to_count <= to_count + 1; last_to <= cyc; end
  end

  // FIR engine model: done is sampled fir_delay edges after the edge that samples go.
  // It keeps counting through a controller reset so a late done can be produced.
  always @(negedge clk) begin
    if (model_cnt >= 0) model_cnt = model_cnt + 1;
    if (fir_go) model_cnt = 0;
    fir_done = (fir_delay > 0) && (model_cnt == fir_delay);
    fir_out_sample = fir_done ? fir_result : 16'h0BAD;
    if (fir_done) model_cnt = -1;
  end

  task automatic send(input bit do_x, input bit do_e,
                      input logic signed [15:0] xv, input logic signed [15:0] dv,
                      input logic signed [15:0] ev, input logic signed [15:0] mv);
    @(negedge clk);
    x_valid = do_x; e_valid = do_e;
    x_data = xv; d_data = dv; e_data = ev; mu = mv;
    cap = cyc + 1;
    @(negedge clk);
    x_valid = 1'b0; e_valid = 1'b0;
  endtask

  task automatic wait_y(input int y0, input int budget);
    for (int i = 0; i < budget && yv_count == y0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({fir_x_in, fir_a_in, fir_weight_adjust, y_data} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", {fir_x_in, fir_a_in, fir_weight_adjust, y_data}); end
    tests++; if ({fir_go, y_valid, busy, overrun, timeout_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {fir_go, y_valid, busy, overrun, timeout_err}); end
    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    int g0, y0;
    g0 = go_count; y0 = yv_count; fir_delay = 136; fir_result = 16'h1234;
    send(1, 1, 16'h1000, 16'h0100, 16'h4000, 16'h4000);
    wait_y(y0, 400);
    tests++; if (yv_count == y0) begin fails++; $display("FAIL basic_wait: got no y_valid want y_valid within 400 cycles"); end
    tests++; if (fir_weight_adjust !== 16'h2000) begin fails++; $display("FAIL basic_wadj: got %h want 2000", fir_weight_adjust); end
    tests++; if (fir_x_in !== 16'h1000) begin fails++; $display("FAIL basic_x_in: got %h want 1000", fir_x_in); end
    tests++; if (fir_a_in !== 16'h0100) begin fails++; $display("FAIL basic_a_in: got %h want 0100", fir_a_in); end
    tests++; if (last_go - cap !== 3) begin fails++; $display("FAIL basic_go_latency: got %0d want 3", last_go - cap); end
    tests++; if (last_yv - last_go !== 136) begin fails++; $display("FAIL basic_done_edge: got %0d want 136", last_yv - last_go); end
    tests++; if (y_data !== 16'h1234) begin fails++; $display("FAIL basic_y: got %h want 1234", y_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    tests++; if (go_count - g0 !== 1) begin fails++; $display("FAIL basic_go_once: got %0d want 1", go_count - g0); end
    tests++; if (yv_count - y0 !== 1) begin fails++; $display("FAIL basic_yv_once: got %0d want 1", yv_count - y0); end
    $display("[TB] test_basic y=%h wadj=%h", y_data, fir_weight_adjust);
  endtask

  task automatic test_saturation;
    int y0;
    fir_delay = 10; fir_result = 16'h0011;
    y0 = yv_count;
    send(1, 1, 16'h0001, 16'h0002, 16'h8000, 16'h8000);
    wait_y(y0, 100);
    tests++; if (fir_weight_adjust !== 16'h7FFF) begin fails++; $display("FAIL sat_pos: got %h want 7fff", fir_weight_adjust); end
    y0 = yv_count;
    send(1, 1, 16'h0003, 16'h0004, 16'h8000, 16'h7FFF);
    wait_y(y0, 100);
    tests++; if (fir_weight_adjust !== 16'h8001) begin fails++; $display("FAIL sat_neg: got %h want 8001", fir_weight_adjust); end
    $display("[TB] test_saturation wadj=%h", fir_weight_adjust);
  endtask

  task automatic test_staggered;
    int g0, o0, y0;
    g0 = go_count; o0 = ovr_count; y0 = yv_count; fir_delay = 12; fir_result = 16'h0777;
    send(1, 0, 16'h0111, 16'h0222, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0 || go_count != g0) begin fails++;
      $display("FAIL stag_x_only: got busy=%b go=%0d want busy=0 go=0", busy, go_count - g0); end
    send(1, 0, 16'h0333, 16'h0444, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    tests++; if (ovr_count - o0 !== 1) begin fails++; $display("FAIL stag_overwrite_ovr: got %0d want 1", ovr_count - o0); end
    send(0, 1, 16'h7777, 16'h7777, 16'h2000, 16'h4000);
    wait_y(y0, 100);
    tests++; if (last_go - cap !== 3) begin fails++; $display("FAIL stag_go_after_e: got %0d want 3", last_go - cap); end
    tests++; if (fir_x_in !== 16'h0333 || fir_a_in !== 16'h0444) begin fails++;
      $display("FAIL stag_operands: got %h/%h want 0333/0444", fir_x_in, fir_a_in); end
    tests++; if (fir_weight_adjust !== 16'h1000) begin fails++; $display("FAIL stag_wadj: got %h want 1000", fir_weight_adjust); end
    tests++; if (y_data !== 16'h0777) begin fails++; $display("FAIL stag_y: got %h want 0777", y_data); end
    $display("[TB] test_staggered x_in=%h", fir_x_in);
  endtask

  task automatic test_enable;
    int g0, o0, y0;
    g0 = go_count; o0 = ovr_count; y0 = yv_count; fir_delay = 15; fir_result = 16'h0321;
    enable = 1'b0;
    send(1, 1, 16'h0AAA, 16'h0BBB, 16'h4000, 16'h4000);
    repeat (4) @(negedge clk);
    tests++; if (go_count != g0 || busy !== 1'b0) begin fails++;
      $display("FAIL en_ignored: got go=%0d busy=%b want go=0 busy=0", go_count - g0, busy); end
    enable = 1'b1;
    send(1, 0, 16'h0555, 16'h0666, 16'h0000, 16'h0000);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    send(0, 1, 16'h0000, 16'h0000, 16'h4000, 16'h4000);
    repeat (5) @(negedge clk);
    tests++; if (go_count != g0) begin fails++; $display("FAIL en_flag_cleared: got go=%0d want 0", go_count - g0); end
    send(1, 0, 16'h0123, 16'h0456, 16'h0000, 16'h0000);
    wait_y(y0, 100);
    tests++; if (fir_x_in !== 16'h0123 || y_data !== 16'h0321) begin fails++;
      $display("FAIL en_resume: got x_in=%h y=%h want 0123/0321", fir_x_in, y_data); end
    tests++; if (ovr_count != o0) begin fails++; $display("FAIL en_no_ovr: got %0d want 0", ovr_count - o0); end
    $display("[TB] test_enable y=%h", y_data);
  endtask

  task automatic test_overrun_wait;
    int g0, o0, y0, g1;
    g0 = go_count; o0 = ovr_count; y0 = yv_count; fir_delay = 136; fir_result = 16'h4321;
    send(1, 1, 16'h0A0A, 16'h0B0B, 16'h1000, 16'h1000);
    repeat (20) @(negedge clk);
    send(1, 0, 16'h7777, 16'h7777, 16'h0000, 16'h0000);
    wait_y(y0, 400);
    tests++; if (ovr_count - o0 !== 1) begin fails++; $display("FAIL ovr_wait_pulse: got %0d want 1", ovr_count - o0); end
    tests++; if (go_count - g0 !== 1) begin fails++; $display("FAIL ovr_wait_go: got %0d want 1", go_count - g0); end
    tests++; if (y_data !== 16'h4321 || fir_x_in !== 16'h0A0A) begin fails++;
      $display("FAIL ovr_wait_result: got y=%h x_in=%h want 4321/0a0a", y_data, fir_x_in); end
    g1 = go_count;
    send(0, 1, 16'h0000, 16'h0000, 16'h1000, 16'h1000);
    repeat (6) @(negedge clk);
    tests++; if (go_count != g1) begin fails++; $display("FAIL ovr_no_flag: got go=%0d want 0", go_count - g1); end
    fir_delay = 10; fir_result = 16'h0E0E; y0 = yv_count;
    send(1, 0, 16'h0C0C, 16'h0D0D, 16'h0000, 16'h0000);
    wait_y(y0, 100);
    tests++; if (fir_x_in !== 16'h0C0C || y_data !== 16'h0E0E) begin fails++;
      $display("FAIL ovr_next_pass: got x_in=%h y=%h want 0c0c/0e0e", fir_x_in, y_data); end
    $display("[TB] test_overrun_wait ovr=%0d", ovr_count - o0);
  endtask

  task automatic test_timeout;
    int t0, y0;
    fir_delay = 0; t0 = to_count; y0 = yv_count;
    send(1, 1, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    for (int i = 0; i < 700 && to_count == t0; i++) @(negedge clk);
    tests++; if (to_count - t0 !== 1) begin fails++; $display("FAIL to_pulse: got %0d want 1", to_count - t0); end
    tests++; if (last_to - last_go !== 512) begin fails++; $display("FAIL to_edge: got %0d want 512", last_to - last_go); end
    tests++; if (yv_count != y0 || busy !== 1'b0) begin fails++;
      $display("FAIL to_no_y: got yv=%0d busy=%b want 0/0", yv_count - y0, busy); end
    tests++; if (y_data !== 16'h0E0E) begin fails++; $display("FAIL to_y_hold: got %h want 0e0e", y_data); end
    fir_delay = 30; fir_result = 16'h0ABC; y0 = yv_count;
    send(1, 1, 16'h0505, 16'h0606, 16'h0707, 16'h0808);
    wait_y(y0, 100);
    tests++; if (y_data !== 16'h0ABC || yv_count - y0 !== 1) begin fails++;
      $display("FAIL to_recover: got y=%h yv=%0d want 0abc/1", y_data, yv_count - y0); end
    $display("[TB] test_timeout abort_after=%0d", last_to - last_go);
  endtask

  task automatic test_reset_mid_wait;
    int g0, y0;
    fir_delay = 136; fir_result = 16'h5555; g0 = go_count; y0 = yv_count;
    send(1, 1, 16'h1111, 16'h2222, 16'h3000, 16'h3000);
    for (int i = 0; i < 20 && go_count == g0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if ({fir_x_in, fir_a_in, fir_weight_adjust, y_data} !== 64'h0) begin
      fails++; $display("FAIL rst_wait_data: got %h want 0", {fir_x_in, fir_a_in, fir_weight_adjust, y_data}); end
    tests++; if ({fir_go, y_valid, busy, overrun, timeout_err} !== 5'b0) begin
      fails++; $display("FAIL rst_wait_ctrl: got %b want 00000", {fir_go, y_valid, busy, overrun, timeout_err}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    tests++; if (yv_count != y0 || busy !== 1'b0) begin fails++;
      $display("FAIL rst_late_done: got yv=%0d busy=%b want 0/0", yv_count - y0, busy); end
    fir_delay = 40; fir_result = 16'h0F0F;
    send(1, 1, 16'h0F00, 16'h00F0, 16'h4000, 16'h4000);
    wait_y(y0, 100);
    tests++; if (y_data !== 16'h0F0F || yv_count - y0 !== 1) begin fails++;
      $display("FAIL rst_recover: got y=%h yv=%0d want 0f0f/1", y_data, yv_count - y0); end
    $display("[TB] test_reset_mid_wait y=%h", y_data);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturation;
    test_staggered;
    test_enable;
    test_overrun_wait;
    test_timeout;
    test_reset_mid_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
